// File: rtl/sram_pkg.sv
// sram_pkg: PDK ids and the byte-merge helper shared by the array write path and collision forwarding
package sram_pkg;
  localparam int PDK_FPGA = 0;
  localparam int PDK_SKY130 = 1;
  localparam int PDK_GF180 = 2;
  localparam int MAX_BYTES = 32;
  localparam int MAX_W = 8 * MAX_BYTES;
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_word, input logic [MAX_W-1:0] new_word, input logic [MAX_BYTES-1:0] mask);
    byte_merge = old_word;
    for (int i = 0; i < MAX_BYTES; i++)
      if (mask[i]) byte_merge[8*i+:8] = new_word[8*i+:8];
  endfunction
endpackage

// File: rtl/sram_dual_port_wrapper_if.sv
// sram_dual_port_wrapper_if: primary 1RW and secondary 1R port bundle
interface sram_dual_port_wrapper_if #(parameter int BYTE_COUNT = 4, parameter int ADDRESS_SIZE = 9);
  localparam int WORD_SIZE = 8 * BYTE_COUNT;
  logic primary_select;
  logic primary_write_enable;
  logic [BYTE_COUNT-1:0] primary_write_mask;
  logic [ADDRESS_SIZE-1:0] primary_address;
  logic [WORD_SIZE-1:0] primary_data_write;
  logic [WORD_SIZE-1:0] primary_data_read;
  logic secondary_select;
  logic [ADDRESS_SIZE-1:0] secondary_address;
  logic [WORD_SIZE-1:0] secondary_data_read;
  modport master(output primary_select, primary_write_enable, primary_write_mask, primary_address, primary_data_write, secondary_select, secondary_address, input primary_data_read, secondary_data_read);
  modport slave(input primary_select, primary_write_enable, primary_write_mask, primary_address, primary_data_write, secondary_select, secondary_address, output primary_data_read, secondary_data_read);
endinterface

// File: rtl/sram_dp_array.sv
// sram_dp_array: raw 1RW + 1R storage with byte-masked write and clock-enabled registered reads
module sram_dp_array
  import sram_pkg::*;
#(
  parameter int BYTE_COUNT = 4,
  parameter int ADDRESS_SIZE = 9,
  localparam int WORD_SIZE = 8 * BYTE_COUNT
) (
  input  logic clk,
  input  logic a_en,
  input  logic a_we,
  input  logic [BYTE_COUNT-1:0] a_mask,
  input  logic [ADDRESS_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0] a_wdata,
  output logic [WORD_SIZE-1:0] a_rdata,
  input  logic b_en,
  input  logic [ADDRESS_SIZE-1:0] b_addr,
  output logic [WORD_SIZE-1:0] b_rdata
);
  logic [WORD_SIZE-1:0] mem [2**ADDRESS_SIZE];
  // Masked write and both reads share the edge; reads see the pre-write word
  always_ff @(posedge clk) begin
    if (a_en & a_we) mem[a_addr] <= WORD_SIZE'(byte_merge(MAX_W'(mem[a_addr]), MAX_W'(a_wdata), MAX_BYTES'(a_mask)));
    if (a_en & ~a_we) a_rdata <= mem[a_addr];
    if (b_en) b_rdata <= mem[b_addr];
  end
endmodule

// File: rtl/sram_dual_port_wrapper.sv
// sram_dual_port_wrapper: behavioural dual-port SRAM with reset, output hold and optional collision forwarding (SRAM_COLLISION_FORWARD_EN)
module sram_dual_port_wrapper
  import sram_pkg::*;
#(
  parameter int BYTE_COUNT = 4,
  parameter int ADDRESS_SIZE = 9
) (
  input logic clk,
  input logic rst,
  sram_dual_port_wrapper_if.slave bus
);
  localparam int WORD_SIZE = 8 * BYTE_COUNT;
  logic a_en, b_en, a_rd_q, b_rd_q;
  logic [WORD_SIZE-1:0] raw_a, raw_b, fresh_b, hold_a, hold_b, read_a, read_b;
  assign a_en = bus.primary_select & ~rst;
  assign b_en = bus.secondary_select & ~rst;
  sram_dp_array #(.BYTE_COUNT(BYTE_COUNT), .ADDRESS_SIZE(ADDRESS_SIZE)) u_array (
    .clk(clk),
    .a_en(a_en),
    .a_we(bus.primary_write_enable),
    .a_mask(bus.primary_write_mask),
    .a_addr(bus.primary_address),
    .a_wdata(bus.primary_data_write),
    .a_rdata(raw_a),
    .b_en(b_en),
    .b_addr(bus.secondary_address),
    .b_rdata(raw_b)
  );
  // Remember which ports got fresh array data; otherwise the last presented word is replayed
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rd_q <= 1'b0;
      b_rd_q <= 1'b0;
      hold_a <= '0;
      hold_b <= '0;
    end else begin
      a_rd_q <= a_en & ~bus.primary_write_enable;
      b_rd_q <= b_en;
      hold_a <= read_a;
      hold_b <= read_b;
    end
  end
`ifdef SRAM_COLLISION_FORWARD_EN
  logic col_q;
  logic [WORD_SIZE-1:0] fwd_data_q;
  logic [BYTE_COUNT-1:0] fwd_mask_q;
  // Capture a same-address primary write so the secondary read can be patched write-first
  always_ff @(posedge clk) begin
    col_q <= ~rst & b_en & a_en & bus.primary_write_enable & (bus.secondary_address == bus.primary_address);
    fwd_data_q <= bus.primary_data_write;
    fwd_mask_q <= bus.primary_write_mask;
  end
  assign fresh_b = col_q ? WORD_SIZE'(byte_merge(MAX_W'(raw_b), MAX_W'(fwd_data_q), MAX_BYTES'(fwd_mask_q))) : raw_b;
`else
  assign fresh_b = raw_b;
`endif
  assign read_a = a_rd_q ? raw_a : hold_a;
  assign read_b = b_rd_q ? fresh_b : hold_b;
  assign bus.primary_data_read = read_a;
  assign bus.secondary_data_read = read_b;
endmodule

// File: tb/tb_sram_dual_port_wrapper.sv
// tb_sram_dual_port_wrapper: scoreboard bench for the dual-port SRAM wrapper
module tb_sram_dual_port_wrapper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [31:0] model [512];
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] want, last_a, last_b;
  sram_dual_port_wrapper_if #(.BYTE_COUNT(4), .ADDRESS_SIZE(9)) bus ();
  sram_dual_port_wrapper #(.BYTE_COUNT(4), .ADDRESS_SIZE(9)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic cyc(input logic psel, input logic pwe, input logic [3:0] mask, input logic [8:0] paddr, input logic [31:0] pdata, input logic ssel, input logic [8:0] saddr);
    bus.primary_select = psel;
    bus.primary_write_enable = pwe;
    bus.primary_write_mask = mask;
    bus.primary_address = paddr;
    bus.primary_data_write = pdata;
    bus.secondary_select = ssel;
    bus.secondary_address = saddr;
    if (!rst && psel && !pwe) exp_a.push_back(model[paddr]);
`ifndef SRAM_COLLISION_FORWARD_EN
    if (!rst && ssel) exp_b.push_back(model[saddr]);
`endif
    if (!rst && psel && pwe)
      for (int i = 0; i < 4; i++)
        if (mask[i]) model[paddr][8*i+:8] = pdata[8*i+:8];
`ifdef SRAM_COLLISION_FORWARD_EN
    if (!rst && ssel) exp_b.push_back(model[saddr]);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(1, 1, 4'hf, 9'd3, 32'h12345678, 1, 9'd3);
    total++; if (bus.primary_data_read !== 32'h0) begin bad++; $display("FAIL reset_a: got %h want 0", bus.primary_data_read); end
    total++; if (bus.secondary_data_read !== 32'h0) begin bad++; $display("FAIL reset_b: got %h want 0", bus.secondary_data_read); end
    cyc(0, 0, 4'h0, 9'd0, 32'h0, 0, 9'd0);
    rst = 1'b0;
    cyc(1, 1, 4'hf, 9'd3, 32'hCAFEF00D, 0, 9'd0);
    total++; if (bus.primary_data_read !== 32'h0) begin bad++; $display("FAIL post_reset_hold: got %h want 0", bus.primary_data_read); end
    cyc(1, 0, 4'h0, 9'd3, 32'h0, 1, 9'd3);
    want = exp_a.pop_front(); last_a = want;
    total++; if (bus.primary_data_read !== want) begin bad++; $display("FAIL readback3_a: got %h want %h", bus.primary_data_read, want); end
    want = exp_b.pop_front(); last_b = want;
    total++; if (bus.secondary_data_read !== want) begin bad++; $display("FAIL readback3_b: got %h want %h", bus.secondary_data_read, want); end
    rst = 1'b1;
    cyc(1, 1, 4'hf, 9'd3, 32'h12345678, 1, 9'd3);
    cyc(1, 1, 4'hf, 9'd3, 32'h12345678, 0, 9'd0);
    total++; if (bus.primary_data_read !== 32'h0 || bus.secondary_data_read !== 32'h0) begin bad++; $display("FAIL reset2: got %h/%h want 0/0", bus.primary_data_read, bus.secondary_data_read); end
    rst = 1'b0;
    cyc(1, 0, 4'h0, 9'd3, 32'h0, 0, 9'd0);
    want = exp_a.pop_front(); last_a = want; last_b = 32'h0;
    total++; if (bus.primary_data_read !== 32'hCAFEF00D) begin bad++; $display("FAIL write_in_reset: got %h want cafef00d", bus.primary_data_read); end
  endtask

  task automatic test_full_write;
    cyc(1, 1, 4'hf, 9'd5, 32'hDEADBEEF, 0, 9'd0);
    total++; if (bus.primary_data_read !== last_a) begin bad++; $display("FAIL write_cycle_hold: got %h want %h", bus.primary_data_read, last_a); end
    cyc(1, 0, 4'h0, 9'd5, 32'h0, 0, 9'd0);
    want = exp_a.pop_front(); last_a = want;
    total++; if (bus.primary_data_read !== want) begin bad++; $display("FAIL full_write: got %h want %h", bus.primary_data_read, want); end
  endtask

  task automatic test_byte_mask;
    cyc(1, 1, 4'b0101, 9'd5, 32'h11223344, 0, 9'd0);
    cyc(1, 0, 4'h0, 9'd5, 32'h0, 0, 9'd0);
    want = exp_a.pop_front(); last_a = want;
    total++; if (bus.primary_data_read !== want) begin bad++; $display("FAIL byte_mask: got %h want %h", bus.primary_data_read, want); end
    cyc(1, 1, 4'b0000, 9'd5, 32'hFFFFFFFF, 0, 9'd0);
    cyc(1, 0, 4'h0, 9'd5, 32'h0, 1, 9'd5);
    want = exp_a.pop_front(); last_a = want;
    total++; if (bus.primary_data_read !== want) begin bad++; $display("FAIL zero_mask_a: got %h want %h", bus.primary_data_read, want); end
    want = exp_b.pop_front(); last_b = want;
    total++; if (bus.secondary_data_read !== want) begin bad++; $display("FAIL zero_mask_b: got %h want %h", bus.secondary_data_read, want); end
  endtask

  task automatic test_dual_port;
    cyc(1, 1, 4'hf, 9'd0, 32'h0BADC0DE, 0, 9'd0);
    cyc(1, 1, 4'hf, 9'd511, 32'h600DF00D, 0, 9'd0);
    cyc(1, 0, 4'h0, 9'd0, 32'h0, 1, 9'd511);
    want = exp_a.pop_front(); last_a = want;
    total++; if (bus.primary_data_read !== want) begin bad++; $display("FAIL dual_a: got %h want %h", bus.primary_data_read, want); end
    want = exp_b.pop_front(); last_b = want;
    total++; if (bus.secondary_data_read !== want) begin bad++; $display("FAIL dual_b: got %h want %h", bus.secondary_data_read, want); end
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 4'h0, 9'd511, 32'h0, 0, 9'd0);
      total++; if (bus.primary_data_read !== last_a) begin bad++; $display("FAIL hold_a: got %h want %h", bus.primary_data_read, last_a); end
      total++; if (bus.secondary_data_read !== last_b) begin bad++; $display("FAIL hold_b: got %h want %h", bus.secondary_data_read, last_b); end
    end
    cyc(1, 0, 4'h0, 9'd511, 32'h0, 1, 9'd0);
    want = exp_a.pop_front(); last_a = want;
    want = exp_b.pop_front(); last_b = want;
    total++; if (bus.primary_data_read !== 32'h600DF00D || bus.secondary_data_read !== 32'h0BADC0DE) begin bad++; $display("FAIL dual_swap: got %h/%h want 600df00d/0badc0de", bus.primary_data_read, bus.secondary_data_read); end
  endtask

  task automatic test_collision;
    cyc(1, 1, 4'hf, 9'd7, 32'hAAAAAAAA, 0, 9'd0);
    cyc(1, 1, 4'hf, 9'd8, 32'hAAAAAAAA, 0, 9'd0);
    cyc(1, 1, 4'hf, 9'd7, 32'h55555555, 1, 9'd7);
    want = exp_b.pop_front(); last_b = want;
    total++; if (bus.secondary_data_read !== want) begin bad++; $display("FAIL collision_full: got %h want %h", bus.secondary_data_read, want); end
    cyc(1, 1, 4'b0011, 9'd8, 32'h55555555, 1, 9'd8);
    want = exp_b.pop_front(); last_b = want;
    total++; if (bus.secondary_data_read !== want) begin bad++; $display("FAIL collision_part: got %h want %h", bus.secondary_data_read, want); end
    cyc(0, 0, 4'h0, 9'd0, 32'h0, 1, 9'd7);
    want = exp_b.pop_front(); last_b = want;
    total++; if (bus.secondary_data_read !== 32'h55555555) begin bad++; $display("FAIL after_collision: got %h want 55555555", bus.secondary_data_read); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 16; k++) cyc(1, 1, 4'hf, 9'(k + 32), $urandom, 0, 9'd0);
    for (int k = 0; k < 80; k++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 9'($urandom_range(32, 47)), $urandom, 1'($urandom_range(0, 3) != 0), 9'($urandom_range(32, 47)));
      if (exp_a.size() > 0) last_a = exp_a.pop_front();
      if (exp_b.size() > 0) last_b = exp_b.pop_front();
      total++; if (bus.primary_data_read !== last_a) begin bad++; $display("FAIL b2b_a[%0d]: got %h want %h", k, bus.primary_data_read, last_a); end
      total++; if (bus.secondary_data_read !== last_b) begin bad++; $display("FAIL b2b_b[%0d]: got %h want %h", k, bus.secondary_data_read, last_b); end
    end
  endtask

  initial begin
    bus.primary_select = 1'b0;
    bus.primary_write_enable = 1'b0;
    bus.primary_write_mask = 4'h0;
    bus.primary_address = 9'd0;
    bus.primary_data_write = 32'h0;
    bus.secondary_select = 1'b0;
    bus.secondary_address = 9'd0;
    last_a = 32'h0;
    last_b = 32'h0;
    test_reset;
    test_full_write;
    test_byte_mask;
    test_dual_port;
    test_collision;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
